// File: rtl/paicore_reqack_rx64.sv
// paicore_reqack_rx64
//   Upstream stage of the PAICORE receive path. It terminates the chip's
//   4-phase request/acknowledge 32-bit output bus and pairs consecutive
//   words into 64-bit frames. Frames go out on a valid/ready stream through
//   a 2-entry FIFO. When the FIFO is full, acknowledge is withheld, which
//   stalls the chip.
//
//   Optional feature macro: PAICORE_RX_FRAME_CNT_EN
//     defined   -> 32-bit frame_cnt counts pushed frames (wraps)
//     undefined -> frame_cnt tied to 0, no counter logic
//
// Parameters
//   SYNC_STAGES     request synchronizer depth (2..4)
//   HI_FIRST        1: first word of a pair -> tdata[63:32]; 0: -> tdata[31:0]
//   TIMEOUT_CYCLES  cycles waited for the second word of a pair (2..65535)
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   din[31:0]        chip data word, stable while request=1
//   request          chip 4-phase request (asynchronous)
//   acknowledge      registered 4-phase acknowledge to chip
//   m_axis_tready    downstream ready
//   m_axis_tvalid    frame valid (FIFO not empty)
//   m_axis_tdata     FIFO head frame
//   frame_cnt[31:0]  frames pushed since reset (0 when feature disabled)
//   half_frame_err   1-cycle pulse when a partial pair is discarded on timeout
module paicore_reqack_rx64 #(
    parameter int SYNC_STAGES    = 2,
    parameter int HI_FIRST       = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    input  logic        request,
    output logic        acknowledge,
    input  logic        m_axis_tready,
    output logic        m_axis_tvalid,
    output logic [63:0] m_axis_tdata,
    output logic [31:0] frame_cnt,
    output logic        half_frame_err
);

    typedef enum logic {WAIT_REQ, WAIT_REL} state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    logic                   idx;
    logic [31:0]            word0;
    logic [15:0]            tcnt;
    logic                   capture, release_req, push, pop, tmo_run, timeout;
    logic [63:0]            pair;
    logic [63:0]            mem [2];
    logic                   wr_ptr, rd_ptr;
    logic [1:0]             count;

    // Request synchronizer; the chain is cleared on reset so a request still
    // high afterwards re-synchronizes and is handled as a new first word.
    always_ff @(posedge clk) begin
        if (rst) req_sync <= '0;
        else     req_sync <= {req_sync[SYNC_STAGES-2:0], request};
    end
    assign req_s = req_sync[SYNC_STAGES-1];

    // Handshake FSM. A capture is refused while the FIFO is full, for either
    // word of a pair, so a push can never hit a full FIFO.
    always_comb begin
        state_nx    = state;
        capture     = 1'b0;
        release_req = 1'b0;
        case (state)
            WAIT_REQ: if (req_s && count != 2'd2) begin
                capture  = 1'b1;
                state_nx = WAIT_REL;
            end
            WAIT_REL: if (!req_s) begin
                release_req = 1'b1;
                state_nx    = WAIT_REQ;
            end
            default: state_nx = WAIT_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_REQ;
            acknowledge <= 1'b0;
        end else begin
            state       <= state_nx;
            acknowledge <= (state_nx == WAIT_REL);
        end
    end

    // Second-word timeout: runs only while waiting for word 1 and the FIFO
    // has room (a downstream stall must not count as a chip fault). A capture
    // in the same cycle wins over the timeout.
    assign tmo_run = (state == WAIT_REQ) && idx && (count != 2'd2);
    assign timeout = tmo_run && !capture && (tcnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || capture || timeout) tcnt <= '0;
        else if (tmo_run)              tcnt <= tcnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx            <= 1'b0;
            word0          <= '0;
            half_frame_err <= 1'b0;
        end else begin
            half_frame_err <= timeout;
            if (capture && !idx) word0 <= din;
            // Timeout drops the partial pair; the next capture overwrites word0.
            if (timeout)          idx <= 1'b0;
            else if (release_req) idx <= ~idx;
        end
    end

    assign push = capture && idx;
    assign pair = (HI_FIRST != 0) ? {word0, din} : {din, word0};

    // 2-entry FIFO
    assign pop = (count != 2'd0) && m_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= pair;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign m_axis_tvalid = (count != 2'd0);
    assign m_axis_tdata  = mem[rd_ptr];

`ifdef PAICORE_RX_FRAME_CNT_EN
    logic [31:0] fcnt;
    always_ff @(posedge clk) begin
        if (rst)       fcnt <= '0;
        else if (push) fcnt <= fcnt + 32'd1;
    end
    assign frame_cnt = fcnt;
`else
    assign frame_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_paicore_reqack_rx64.sv
module tb_paicore_reqack_rx64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = '0;
    logic        request = 1'b0;
    logic        m_axis_tready = 1'b0;
    logic        acknowledge, m_axis_tvalid, half_frame_err;
    logic [63:0] m_axis_tdata;
    logic [31:0] frame_cnt;
    logic        ack2, tvalid2, err2;
    logic [63:0] tdata2;
    logic [31:0] fcnt2;

    int n_cmp = 0;
    int n_err = 0;
    int err_pulses = 0;
    bit done;
    logic [63:0] got[$];
    logic [63:0] got2[$];

`ifdef PAICORE_RX_FRAME_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    paicore_reqack_rx64 #(.SYNC_STAGES(2), .HI_FIRST(1), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .din(din), .request(request), .acknowledge(acknowledge),
        .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata(m_axis_tdata), .frame_cnt(frame_cnt), .half_frame_err(half_frame_err));

    // Same stimulus, opposite word order; used for the HI_FIRST=0 check.
    paicore_reqack_rx64 #(.SYNC_STAGES(2), .HI_FIRST(0), .TIMEOUT_CYCLES(16)) dut2 (
        .clk(clk), .rst(rst), .din(din), .request(request), .acknowledge(ack2),
        .m_axis_tready(m_axis_tready), .m_axis_tvalid(tvalid2),
        .m_axis_tdata(tdata2), .frame_cnt(fcnt2), .half_frame_err(err2));

    always #5 clk = ~clk;

    // Beat / error-pulse monitor, sampled after all negedge stimulus has settled.
    always begin
        @(negedge clk);
        #1;
        if (m_axis_tvalid && m_axis_tready) got.push_back(m_axis_tdata);
        if (tvalid2 && m_axis_tready)       got2.push_back(tdata2);
        if (half_frame_err)                 err_pulses++;
    end

    task automatic do_reset();
        @(negedge clk);
        m_axis_tready = 1'b0;
        request = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got.delete();
        got2.delete();
        err_pulses = 0;
    endtask

    task automatic wait_ack(input logic v, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (acknowledge === v) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: acknowledge never reached %0b within 200 cycles", tag, v);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        wait_ack(1'b0, "ack_idle");
        din = w;
        request = 1'b1;
        wait_ack(1'b1, "ack_rise");
        request = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 5;
        if (acknowledge !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %0b want 0", acknowledge); end
        if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %0b want 0", m_axis_tvalid); end
        if (m_axis_tdata !== 64'd0) begin n_err++; $display("FAIL rst_tdata: got %h want 0", m_axis_tdata); end
        if (frame_cnt !== 32'd0) begin n_err++; $display("FAIL rst_fcnt: got %0d want 0", frame_cnt); end
        if (half_frame_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %0b want 0", half_frame_err); end
    endtask

    task automatic test_word_order();
        int lat = 0;
        do_reset();
        m_axis_tready = 1'b1;
        send_word(32'hDEADBEEF);
        // Second word: measure request rise -> tvalid
        wait_ack(1'b0, "ack_idle2");
        din = 32'h01234567;
        request = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            lat++;
            if (m_axis_tvalid) break;
        end
        n_cmp++;
        if (lat != 3) begin n_err++; $display("FAIL latency: got %0d want 3", lat); end
        wait_ack(1'b1, "ack_rise2");
        request = 1'b0;
        wait_ack(1'b0, "ack_fall2");
        repeat (3) @(negedge clk);
        n_cmp += 5;
        if (got.size() != 1 || got2.size() != 1) begin
            n_err++; $display("FAIL beats: got %0d/%0d want 1/1", got.size(), got2.size());
        end
        if (got.size() < 1 || got[0] !== 64'hDEADBEEF01234567) begin
            n_err++; $display("FAIL hi_first1: got %h want deadbeef01234567", (got.size() > 0) ? got[0] : 64'hx);
        end
        if (got2.size() < 1 || got2[0] !== 64'h01234567DEADBEEF) begin
            n_err++; $display("FAIL hi_first0: got %h want 01234567deadbeef", (got2.size() > 0) ? got2[0] : 64'hx);
        end
        if (frame_cnt !== (CNT_ON ? 32'd1 : 32'd0)) begin
            n_err++; $display("FAIL fcnt1: got %0d want %0d", frame_cnt, CNT_ON ? 1 : 0);
        end
        if (err_pulses != 0) begin n_err++; $display("FAIL err1: got %0d pulses want 0", err_pulses); end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp [3];
        exp[0] = 64'h11111111_22222222;
        exp[1] = 64'h33333333_44444444;
        exp[2] = 64'h55555555_66666666;
        do_reset();
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        send_word(32'h44444444);
        repeat (2) @(negedge clk);
        din = 32'h55555555;
        request = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp += 3;
        if (acknowledge !== 1'b0) begin n_err++; $display("FAIL bp_ack_withheld: got %0b want 0", acknowledge); end
        if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL bp_tvalid: got %0b want 1", m_axis_tvalid); end
        if (m_axis_tdata !== exp[0]) begin n_err++; $display("FAIL bp_hold: got %h want %h", m_axis_tdata, exp[0]); end
        m_axis_tready = 1'b1;
        wait_ack(1'b1, "bp_ack_resume");
        request = 1'b0;
        wait_ack(1'b0, "bp_ack_fall");
        send_word(32'h66666666);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (got.size() != 3) begin n_err++; $display("FAIL bp_beats: got %0d want 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                n_err++; $display("FAIL bp_order%0d: got %h want %h", i, (i < got.size()) ? got[i] : 64'hx, exp[i]);
            end
        end
        n_cmp++;
        if (frame_cnt !== (CNT_ON ? 32'd3 : 32'd0)) begin
            n_err++; $display("FAIL bp_fcnt: got %0d want %0d", frame_cnt, CNT_ON ? 3 : 0);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        m_axis_tready = 1'b1;
        send_word(32'hAAAAAAAA);
        repeat (30) @(negedge clk);
        n_cmp += 2;
        if (err_pulses != 1) begin n_err++; $display("FAIL tmo_pulse: got %0d pulses want 1", err_pulses); end
        if (got.size() != 0) begin n_err++; $display("FAIL tmo_nobeat: got %0d beats want 0", got.size()); end
        send_word(32'hC0C0C0C0);
        send_word(32'hD0D0D0D0);
        repeat (4) @(negedge clk);
        n_cmp += 2;
        if (got.size() != 1 || got[0] !== 64'hC0C0C0C0_D0D0D0D0) begin
            n_err++; $display("FAIL tmo_clean: got %h (%0d beats) want c0c0c0c0d0d0d0d0",
                              (got.size() > 0) ? got[0] : 64'hx, got.size());
        end
        if (err_pulses != 1) begin n_err++; $display("FAIL tmo_once: got %0d pulses want 1", err_pulses); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_word(32'h12345678);
        send_word(32'h9ABCDEF0);
        din = 32'h0BADF00D;
        request = 1'b1;
        wait_ack(1'b1, "mid_ack_rise");
        rst = 1'b1;
        @(negedge clk);
        n_cmp += 4;
        if (acknowledge !== 1'b0) begin n_err++; $display("FAIL mid_ack: got %0b want 0", acknowledge); end
        if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_tvalid: got %0b want 0", m_axis_tvalid); end
        if (m_axis_tdata !== 64'd0) begin n_err++; $display("FAIL mid_tdata: got %h want 0", m_axis_tdata); end
        if (frame_cnt !== 32'd0) begin n_err++; $display("FAIL mid_fcnt: got %0d want 0", frame_cnt); end
        request = 1'b0;
        rst = 1'b0;
        got.delete();
        repeat (3) @(negedge clk);
        m_axis_tready = 1'b1;
        send_word(32'hE1E1E1E1);
        send_word(32'hE2E2E2E2);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (got.size() != 1 || got[0] !== 64'hE1E1E1E1_E2E2E2E2) begin
            n_err++; $display("FAIL mid_after: got %h (%0d beats) want e1e1e1e1e2e2e2e2",
                              (got.size() > 0) ? got[0] : 64'hx, got.size());
        end
    endtask

    task automatic test_random();
        logic [63:0] exp[$];
        do_reset();
        done = 1'b0;
        fork
            begin
                logic [31:0] prev = '0;
                for (int i = 0; i < 200; i++) begin
                    logic [31:0] w = $urandom;
                    if (i % 2 == 1) exp.push_back({prev, w});
                    prev = w;
                    send_word(w);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    m_axis_tready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        m_axis_tready = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp += 3;
        if (got.size() != 100) begin n_err++; $display("FAIL rnd_beats: got %0d want 100", got.size()); end
        if (frame_cnt !== (CNT_ON ? 32'd100 : 32'd0)) begin
            n_err++; $display("FAIL rnd_fcnt: got %0d want %0d", frame_cnt, CNT_ON ? 100 : 0);
        end
        if (err_pulses != 0) begin n_err++; $display("FAIL rnd_err: got %0d pulses want 0", err_pulses); end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                n_err++; $display("FAIL rnd_frame%0d: got %h want %h", i, (i < got.size()) ? got[i] : 64'hx, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_order();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
